// File: rtl/tbb1143_bus_writer.sv
// tbb1143_bus_writer
//
// Host-side write stage for the TBB1143 sound core. Register-write commands
// (4-bit address plus 8-bit data) arrive over a valid/ready handshake and are
// buffered in a small FIFO. Each command is then sent to the core's nibble bus
// as three nibbles: the address with A0=1, then the data low and high nibbles
// with A0=0. Every nibble gets a setup, strobe and hold phase of programmable
// length.
//
// Ports
//   CLK       system clock; all state changes on its rising edge
//   RST       synchronous reset, active-high
//   in_valid  host command valid
//   in_ready  FIFO can accept a command (combinational, !full)
//   in_reg    target register address
//   in_data   register data
//   D         nibble bus to the core's data_in (registered)
//   A0        1 = address nibble, 0 = data nibble (registered)
//   WR        write strobe, active-high (registered)
//   busy      FIFO non-empty or a transfer in progress
//   level     current FIFO occupancy
module tbb1143_bus_writer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned PULSE_CYC  = 2,
    parameter int unsigned HOLD_CYC   = 1,
    localparam int unsigned LvlW      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            CLK,
    input  logic            RST,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      in_reg,
    input  logic [7:0]      in_data,
    output logic [3:0]      D,
    output logic            A0,
    output logic            WR,
    output logic            busy,
    output logic [LvlW-1:0] level
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned MaxCyc =
        (SETUP_CYC > PULSE_CYC) ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int unsigned PhW = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;

    localparam logic [PhW-1:0]  SetupLast = PhW'(SETUP_CYC - 1);
    localparam logic [PhW-1:0]  PulseLast = PhW'(PULSE_CYC - 1);
    localparam logic [PhW-1:0]  HoldLast  = PhW'(HOLD_CYC - 1);
    localparam logic [LvlW-1:0] FullLevel = LvlW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        StIdle,
        StSetup,
        StStrobe,
        StHold
    } state_e;

    // ------------------------------------------------------------------
    // Command FIFO
    // ------------------------------------------------------------------
    logic [11:0]     mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0] level_q, level_d;
    logic            fifo_empty, fifo_full;
    logic            push, pop;
    logic [11:0]     head;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == FullLevel);
    assign in_ready   = !fifo_full;
    assign push       = in_valid && in_ready;
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        level_d = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LvlW'(1);
            2'b01:   level_d = level_q - LvlW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            level_q <= level_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {in_reg, in_data};
        end
    end

    // ------------------------------------------------------------------
    // Serializer FSM
    // ------------------------------------------------------------------
    state_e         state_q, state_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic [1:0]     nib_q, nib_d;
    logic [11:0]    cmd_q, cmd_d;
    logic [3:0]     d_q, d_d;
    logic           a0_q, a0_d;
    logic           wr_q, wr_d;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        nib_d   = nib_q;
        cmd_d   = cmd_q;
        pop     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = head;
                    nib_d   = 2'd0;
                    phase_d = '0;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (phase_q == SetupLast) begin
                    phase_d = '0;
                    state_d = StStrobe;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StStrobe: begin
                if (phase_q == PulseLast) begin
                    phase_d = '0;
                    state_d = StHold;
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            StHold: begin
                if (phase_q == HoldLast) begin
                    phase_d = '0;
                    if (nib_q != 2'd2) begin
                        nib_d   = nib_q + 2'd1;
                        state_d = StSetup;
                    end else if (!fifo_empty) begin
                        // Chain straight into the next command with no idle gap.
                        pop     = 1'b1;
                        cmd_d   = head;
                        nib_d   = 2'd0;
                        state_d = StSetup;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    phase_d = phase_q + PhW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                phase_d = '0;
            end
        endcase
    end

    // Bus outputs are derived from the next state so they can be registered;
    // D/A0 only move on entry to SETUP, so they never change while WR is high.
    always_comb begin
        d_d  = 4'h0;
        a0_d = 1'b0;
        wr_d = 1'b0;
        if (state_d != StIdle) begin
            case (nib_d)
                2'd0:    d_d = cmd_d[11:8];
                2'd1:    d_d = cmd_d[3:0];
                default: d_d = cmd_d[7:4];
            endcase
            a0_d = (nib_d == 2'd0);
            wr_d = (state_d == StStrobe);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            phase_q <= '0;
            nib_q   <= 2'd0;
            cmd_q   <= 12'h000;
            d_q     <= 4'h0;
            a0_q    <= 1'b0;
            wr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            nib_q   <= nib_d;
            cmd_q   <= cmd_d;
            d_q     <= d_d;
            a0_q    <= a0_d;
            wr_q    <= wr_d;
        end
    end

    assign D     = d_q;
    assign A0    = a0_q;
    assign WR    = wr_q;
    assign busy  = (state_q != StIdle) || !fifo_empty;
    assign level = level_q;

endmodule

// File: tb/tb_tbb1143_bus_writer.sv
// Bench for tbb1143_bus_writer. Two instances: u0 with default timing and
// u1 with SETUP=2, PULSE=1, HOLD=3, DEPTH=2. A behavioural model tracks each
// instance as a command queue plus a count of cycles left in the command on
// the bus; expected bus values follow from position arithmetic in that count.
module tb_tbb1143_bus_writer;

    localparam int unsigned DEP0 = 4, S0 = 1, W0 = 2, H0 = 1;
    localparam int unsigned DEP1 = 2, S1 = 2, W1 = 1, H1 = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] valid;
    logic [3:0] regv  [2];
    logic [7:0] datav [2];

    logic       rdy0, rdy1, a0_0, a0_1, wr0, wr1, busy0, busy1;
    logic [3:0] d0, d1;
    logic [2:0] lvl0;
    logic [1:0] lvl1;

    always #5 clk = ~clk;

    tbb1143_bus_writer #(
        .FIFO_DEPTH(DEP0), .SETUP_CYC(S0), .PULSE_CYC(W0), .HOLD_CYC(H0)
    ) u0 (
        .CLK(clk), .RST(rst), .in_valid(valid[0]), .in_ready(rdy0),
        .in_reg(regv[0]), .in_data(datav[0]), .D(d0), .A0(a0_0), .WR(wr0),
        .busy(busy0), .level(lvl0)
    );

    tbb1143_bus_writer #(
        .FIFO_DEPTH(DEP1), .SETUP_CYC(S1), .PULSE_CYC(W1), .HOLD_CYC(H1)
    ) u1 (
        .CLK(clk), .RST(rst), .in_valid(valid[1]), .in_ready(rdy1),
        .in_reg(regv[1]), .in_data(datav[1]), .D(d1), .A0(a0_1), .WR(wr1),
        .busy(busy1), .level(lvl1)
    );

    int    n_checks = 0;
    int    n_errors = 0;
    bit    chk_en   = 1'b0;
    string phase    = "reset";

    // Model state
    logic [11:0] mq0 [$];
    logic [11:0] mq1 [$];
    int          cnt [2];
    logic [11:0] cur [2];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    function automatic int unsigned dep(int g);
        return (g == 0) ? DEP0 : DEP1;
    endfunction
    function automatic int unsigned scyc(int g);
        return (g == 0) ? S0 : S1;
    endfunction
    function automatic int unsigned wcyc(int g);
        return (g == 0) ? W0 : W1;
    endfunction
    function automatic int unsigned per(int g);
        return (g == 0) ? (S0 + W0 + H0) : (S1 + W1 + H1);
    endfunction
    function automatic int qsize(int g);
        return (g == 0) ? mq0.size() : mq1.size();
    endfunction

    // Expected {D, A0, WR} from the position inside the current command.
    function automatic logic [5:0] exp_bus(int g);
        int         p, pos, nib, ph;
        logic [3:0] d;
        logic       a0, wr;
        if (cnt[g] == 0) return 6'd0;
        p   = int'(per(g));
        pos = 3 * p - cnt[g];
        nib = pos / p;
        ph  = pos % p;
        if (nib == 0)      d = cur[g][11:8];
        else if (nib == 1) d = cur[g][3:0];
        else               d = cur[g][7:4];
        a0 = (nib == 0);
        wr = (ph >= int'(scyc(g))) && (ph < int'(scyc(g) + wcyc(g)));
        return {d, a0, wr};
    endfunction

    // Advance the model by one clock edge using pre-edge inputs.
    task automatic model_step();
        int          sz;
        bit          do_push;
        logic [11:0] cmd;
        for (int g = 0; g < 2; g++) begin
            sz      = qsize(g);
            do_push = valid[g] && (sz < int'(dep(g)));
            cmd     = {regv[g], datav[g]};
            if (rst) begin
                if (g == 0) mq0.delete(); else mq1.delete();
                cnt[g] = 0;
            end else begin
                if (cnt[g] > 1) begin
                    cnt[g]--;
                end else if (sz != 0) begin
                    if (g == 0) cur[g] = mq0.pop_front(); else cur[g] = mq1.pop_front();
                    cnt[g] = 3 * int'(per(g));
                end else begin
                    cnt[g] = 0;
                end
                if (do_push) begin
                    if (g == 0) mq0.push_back(cmd); else mq1.push_back(cmd);
                end
            end
        end
    endtask

    task automatic check_all();
        logic [5:0] e, o;
        logic       b, r;
        logic [2:0] l;
        for (int g = 0; g < 2; g++) begin
            e = exp_bus(g);
            if (g == 0) begin
                o = {d0, a0_0, wr0}; b = busy0; r = rdy0; l = lvl0;
            end else begin
                o = {d1, a0_1, wr1}; b = busy1; r = rdy1; l = {1'b0, lvl1};
            end
            check_eq($sformatf("%s.u%0d.D", phase, g), 32'(o[5:2]), 32'(e[5:2]));
            check_eq($sformatf("%s.u%0d.A0", phase, g), 32'(o[1]), 32'(e[1]));
            check_eq($sformatf("%s.u%0d.WR", phase, g), 32'(o[0]), 32'(e[0]));
            check_eq($sformatf("%s.u%0d.busy", phase, g), 32'(b),
                     32'((cnt[g] != 0) || (qsize(g) != 0)));
            check_eq($sformatf("%s.u%0d.level", phase, g), 32'(l), 32'(qsize(g)));
            check_eq($sformatf("%s.u%0d.in_ready", phase, g), 32'(r),
                     32'(qsize(g) < int'(dep(g))));
        end
    endtask

    // One clock: model follows the edge, outputs are compared at the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        if (chk_en) check_all();
    endtask

    task automatic idle(int n);
        valid = '0;
        repeat (n) cycle();
    endtask

    // Hold a command on instance g until accepted.
    task automatic send(int g, logic [3:0] r, logic [7:0] d);
        bit acc;
        int k;
        valid    = '0;
        valid[g] = 1'b1;
        regv[g]  = r;
        datav[g] = d;
        acc      = 1'b0;
        k        = 0;
        while (!acc && k < 200) begin
            acc = (g == 0) ? rdy0 : rdy1;
            cycle();
            k++;
        end
        check_eq($sformatf("%s.u%0d.accept_timeout", phase, g), 32'(acc), 32'd1);
    endtask

    task automatic drain(int g, int limit);
        int   k;
        logic b;
        valid = '0;
        k     = 0;
        b     = (g == 0) ? busy0 : busy1;
        while (b !== 1'b0 && k < limit) begin
            cycle();
            k++;
            b = (g == 0) ? busy0 : busy1;
        end
        check_eq($sformatf("%s.u%0d.drain_timeout", phase, g), 32'(b), 32'd0);
    endtask

    initial begin
        bit found;
        int k;
        rst      = 1'b1;
        valid    = '0;
        regv[0]  = 4'h0; regv[1]  = 4'h0;
        datav[0] = 8'h0; datav[1] = 8'h0;
        cnt[0]   = 0;    cnt[1]   = 0;
        cur[0]   = '0;   cur[1]   = '0;

        cycle();
        chk_en = 1'b1;
        cycle();
        rst   = 1'b0;
        phase = "idle";
        idle(3);

        phase = "single";
        send(0, 4'h5, 8'hA3);
        idle(16);

        phase = "b2b";
        send(0, 4'h1, 8'h22);
        send(0, 4'h2, 8'h44);
        drain(0, 60);

        phase = "full";
        for (int i = 0; i < 6; i++) send(0, 4'(i + 8), 8'($urandom));
        drain(0, 200);

        phase = "midrst";
        send(0, 4'h3, 8'h5C);
        send(0, 4'h6, 8'h7D);
        send(0, 4'h9, 8'hE1);
        valid = '0;
        found = 1'b0;
        k     = 0;
        while (!found && k < 60) begin
            if (wr0 === 1'b1 && a0_0 === 1'b0) found = 1'b1;
            else begin
                cycle();
                k++;
            end
        end
        check_eq("midrst.strobe_reached", 32'(found), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle(20);

        phase = "sweep";
        send(1, 4'hC, 8'h96);
        send(1, 4'h4, 8'h1F);
        send(1, 4'hB, 8'h80);
        send(1, 4'h7, 8'h3E);
        drain(1, 200);

        phase = "random";
        for (int it = 0; it < 40; it++) begin
            int g, n;
            g = int'($urandom_range(1, 0));
            n = int'($urandom_range(4, 1));
            for (int j = 0; j < n; j++) send(g, 4'($urandom), 8'($urandom));
            idle(int'($urandom_range(15, 0)));
        end
        drain(0, 400);
        drain(1, 400);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
